uart_cmd_decoder: RTL and testbench

Command decoder on the read side of the UART RX FIFO. Pops ASCII bytes from the RX FIFO and turns them into one-cycle control pulses for the stopwatch/watch/mode logic, plus a validated time-set command ("T" + hhmmss + CR/LF) that loads the watch. It is the consumer counterpart to the ASCII print generator on the TX side.

---
 rtl/uart_cmd_decoder.sv | 138 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: consumes ASCII bytes from the RX FIFO head and turns them
// into one-cycle control pulses plus a validated "Thhmmss<CR|LF>" time-set.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_rd,
  output logic       btn_run,
  output logic       btn_clear,
  output logic       btn_mode,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       cmd_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DIGIT, TERM} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [5:0][3:0] dig;
  logic [CW-1:0]   cnt;

  logic       is_digit;
  logic       is_term;
  logic [6:0] hr7, mn7, sc7;
  logic       in_range;

  // x*10 as (x<<3)+(x<<1); a two-digit value never exceeds 99, so 7 bits suffice
  function automatic logic [6:0] mul10(input logic [3:0] d);
    logic [6:0] x;
    x = {3'b000, d};
    return (x << 3) + (x << 1);
  endfunction

  // Never stall the FIFO; hold the pop off while in reset
  assign rx_rd = reset & ~rx_empty;
  assign busy  = (state != IDLE);

  // Byte classification and time-field assembly from the stored digits
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    hr7      = mul10(dig[0]) + {3'b000, dig[1]};
    mn7      = mul10(dig[2]) + {3'b000, dig[3]};
    sc7      = mul10(dig[4]) + {3'b000, dig[5]};
    in_range = (hr7 <= 7'd23) && (mn7 <= 7'd59) && (sc7 <= 7'd59);
  end

  // Decoder FSM with registered one-cycle pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      dig       <= '0;
      cnt       <= '0;
      btn_run   <= 1'b0;
      btn_clear <= 1'b0;
      btn_mode  <= 1'b0;
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
    end else begin
      btn_run   <= 1'b0;
      btn_clear <= 1'b0;
      btn_mode  <= 1'b0;
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_rd) begin
            case (rx_data)
              8'h52, 8'h72: btn_run   <= 1'b1;
              8'h43, 8'h63: btn_clear <= 1'b1;
              8'h4D, 8'h6D: btn_mode  <= 1'b1;
              8'h54, 8'h74: begin
                idx   <= '0;
                state <= DIGIT;
              end
              8'h0D, 8'h0A, 8'h20: ;
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        DIGIT: begin
          if (rx_rd) begin
            cnt <= '0;
            if (is_digit) begin
              dig[idx] <= rx_data[3:0];
              idx      <= idx + 3'd1;
              if (idx == 3'd5) state <= TERM;
            end else begin
              cmd_err <= 1'b1;
              state   <= IDLE;
            end
          end else if (cnt == TO_LAST) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TERM: begin
          if (rx_rd) begin
            cnt   <= '0;
            state <= IDLE;
            if (is_term && in_range) begin
              set_hour  <= hr7[4:0];
              set_min   <= mn7[5:0];
              set_sec   <= sc7[5:0];
              set_valid <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end else if (cnt == TO_LAST) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: one byte per cycle from a simple FWFT
// driver, outputs sampled on the falling edge after each popping edge.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rd, btn_run, btn_clear, btn_mode, set_valid, cmd_err, busy;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_rd(rx_rd), .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .cmd_err(cmd_err), .busy(busy)
  );

  // pulse vector {run, clear, mode, set_valid, cmd_err}
  function automatic logic [4:0] pv();
    return {btn_run, btn_clear, btn_mode, set_valid, cmd_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: present a byte (or empty) at the falling edge, let the rising
  // edge pop it, then check the pulse vector on the next falling edge.
  task automatic step(input string tag, input logic emp, input logic [7:0] d,
                      input logic [4:0] exp_p);
    rx_empty = emp;
    rx_data  = d;
    @(posedge clk);
    @(negedge clk);
    chk(tag, {27'd0, pv()}, {27'd0, exp_p});
  endtask

  task automatic idle_cyc(output logic [4:0] p);
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    p = pv();
  endtask

  task automatic send_str(input string tag, input string s, input logic [4:0] exp_last);
    for (int i = 0; i < s.len(); i++)
      step(tag, 1'b0, s[i], (i == s.len() - 1) ? exp_last : 5'b00000);
  endtask

  logic [4:0] p;
  int         hit;
  logic       any;

  initial begin
    reset    = 1'b0;
    rx_empty = 1'b0;
    rx_data  = 8'h52;
    repeat (3) @(negedge clk);
    chk("rst_rx_rd", {31'd0, rx_rd}, 0);
    chk("rst_pulses", {27'd0, pv()}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_set", {15'd0, set_hour, set_min, set_sec}, 0);
    rx_empty = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_rd_empty", {31'd0, rx_rd}, 0);
    rx_empty = 1'b0;
    #1 chk("rx_rd_follow", {31'd0, rx_rd}, 1);
    rx_empty = 1'b1;
    @(negedge clk);

    // Single-byte commands back-to-back
    step("run_R",   1'b0, "R", 5'b10000);
    step("clear_c", 1'b0, "c", 5'b01000);
    step("mode_M",  1'b0, "M", 5'b00100);
    step("space",   1'b0, 8'h20, 5'b00000);
    step("bad_x",   1'b0, "x", 5'b00001);
    step("run_rr1", 1'b0, "r", 5'b10000);
    step("run_rr2", 1'b0, "r", 5'b10000);
    step("idle0",   1'b1, 8'h00, 5'b00000);

    // Valid time-set with CR
    step("t_T", 1'b0, "T", 5'b00000);
    chk("busy_after_T", {31'd0, busy}, 1);
    send_str("t_digits", "123456", 5'b00000);
    chk("busy_before_cr", {31'd0, busy}, 1);
    step("t_cr", 1'b0, 8'h0D, 5'b00010);
    chk("busy_after_cr", {31'd0, busy}, 0);
    chk("set_hms_123456", {15'd0, set_hour, set_min, set_sec}, {15'd0, 5'd12, 6'd34, 6'd56});
    step("idle1", 1'b1, 8'h00, 5'b00000);

    // Upper bound accepted, then out-of-range rejects leave set_* untouched
    send_str("t_235959", {"t235959", 8'h0A}, 5'b00010);
    chk("set_hms_235959", {15'd0, set_hour, set_min, set_sec}, {15'd0, 5'd23, 6'd59, 6'd59});
    send_str("t_240000", {"T240000", 8'h0A}, 5'b00001);
    send_str("t_006000", {"T006000", 8'h0D}, 5'b00001);
    send_str("t_000060", {"T000060", 8'h0D}, 5'b00001);
    send_str("t_noterm", "T000000X", 5'b00001);
    chk("set_hold", {15'd0, set_hour, set_min, set_sec}, {15'd0, 5'd23, 6'd59, 6'd59});

    // Non-digit aborts; trailing bytes decoded fresh in IDLE
    send_str("t_12", "T12", 5'b00000);
    step("t_a", 1'b0, "a", 5'b00001);
    chk("busy_after_a", {31'd0, busy}, 0);
    step("t_4", 1'b0, "4", 5'b00001);
    step("t_5", 1'b0, "5", 5'b00001);
    step("t_6", 1'b0, "6", 5'b00001);
    step("t_cr_ign", 1'b0, 8'h0D, 5'b00000);
    chk("set_hold2", {15'd0, set_hour, set_min, set_sec}, {15'd0, 5'd23, 6'd59, 6'd59});

    // Timeout: cmd_err after the 50th idle edge following the '2' pop
    send_str("to_T12", "T12", 5'b00000);
    hit = 0;
    any = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      idle_cyc(p);
      if (p == 5'b00001 && hit == 0) hit = n;
      else if (p != 5'b00000) any = 1'b1;
    end
    chk("to_cycle", hit, 50);
    chk("to_other_pulses", {31'd0, any}, 0);
    chk("to_busy", {31'd0, busy}, 0);
    step("to_then_R", 1'b0, "R", 5'b10000);

    // A byte arriving on the would-be timeout edge wins
    send_str("bw_T1", "T1", 5'b00000);
    any = 1'b0;
    for (int n = 1; n <= 49; n++) begin
      idle_cyc(p);
      if (p != 5'b00000) any = 1'b1;
    end
    chk("bw_no_err", {31'd0, any}, 0);
    send_str("bw_rest", {"23456", 8'h0D}, 5'b00010);
    chk("set_hms_bw", {15'd0, set_hour, set_min, set_sec}, {15'd0, 5'd12, 6'd34, 6'd56});

    // Reset mid-command discards the partial time
    send_str("mid_T1234", "T1234", 5'b00000);
    rx_empty = 1'b0;
    rx_data  = "5";
    reset    = 1'b0;
    #1;
    chk("mid_rst_pulses", {27'd0, pv()}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_rx_rd", {31'd0, rx_rd}, 0);
    chk("mid_rst_set", {15'd0, set_hour, set_min, set_sec}, 0);
    @(negedge clk);
    rx_empty = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    step("mid_5", 1'b0, "5", 5'b00001);
    step("mid_6", 1'b0, "6", 5'b00001);
    step("mid_cr", 1'b0, 8'h0D, 5'b00000);
    step("mid_idle", 1'b1, 8'h00, 5'b00000);
    chk("mid_set", {15'd0, set_hour, set_min, set_sec}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
